// File: rtl/ssd_scan_ctl.sv
// Four-digit multiplexed seven-segment scan controller with a double-buffered frame load.
// Outputs are registered; the display buffer changes only when the SCAN3 digit period ends.
module ssd_scan_ctl #(
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_blank,
  output logic        load_ready,
  output logic [3:0]  d,
  output logic [3:0]  ssd_ctl,
  output logic        frame_done
);

  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      disp_data, disp_data_nxt, pend_data, pend_data_nxt;
  logic [3:0]       disp_blank, disp_blank_nxt, pend_blank, pend_blank_nxt;
  logic             pend, pend_nxt;
  logic [3:0]       d_nxt, ssd_ctl_nxt;
  logic             tick, boundary, accept;

  assign tick       = &cnt;
  assign boundary   = tick && (state == SCAN3);
  assign load_ready = ~pend;
  assign accept     = load_valid && ~pend;

  always_comb begin
    state_nxt      = state;
    disp_data_nxt  = disp_data;
    disp_blank_nxt = disp_blank;
    pend_data_nxt  = pend_data;
    pend_blank_nxt = pend_blank;
    pend_nxt       = pend;
    d_nxt          = 4'h0;
    ssd_ctl_nxt    = 4'b1111;

    if (tick) begin
      case (state)
        SCAN0:   state_nxt = SCAN1;
        SCAN1:   state_nxt = SCAN2;
        SCAN2:   state_nxt = SCAN3;
        default: state_nxt = SCAN0;
      endcase
    end

    // Commit uses the pending state from before this edge, so a frame accepted
    // on the boundary edge itself waits for the next boundary.
    if (boundary && pend) begin
      disp_data_nxt  = pend_data;
      disp_blank_nxt = pend_blank;
      pend_nxt       = 1'b0;
    end

    if (accept) begin
      pend_data_nxt  = load_data;
      pend_blank_nxt = load_blank;
      pend_nxt       = 1'b1;
    end

    // Drive the outputs from next-cycle state so d/ssd_ctl track state exactly.
    d_nxt = disp_data_nxt[4*int'(state_nxt) +: 4];
    if (!disp_blank_nxt[state_nxt])
      ssd_ctl_nxt[state_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      state      <= SCAN0;
      disp_data  <= 16'h0000;
      disp_blank <= 4'b0000;
      pend_data  <= 16'h0000;
      pend_blank <= 4'b0000;
      pend       <= 1'b0;
      d          <= 4'h0;
      ssd_ctl    <= 4'b1110;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      state      <= state_nxt;
      disp_data  <= disp_data_nxt;
      disp_blank <= disp_blank_nxt;
      pend_data  <= pend_data_nxt;
      pend_blank <= pend_blank_nxt;
      pend       <= pend_nxt;
      d          <= d_nxt;
      ssd_ctl    <= ssd_ctl_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Directed bench for ssd_scan_ctl with CNT_W=2 (digit period 4 cycles, frame 16 cycles).
module tb_ssd_scan_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_blank;
  logic        load_ready;
  logic [3:0]  d;
  logic [3:0]  ssd_ctl;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  ssd_scan_ctl #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_blank (load_blank),
    .load_ready (load_ready),
    .d          (d),
    .ssd_ctl    (ssd_ctl),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        v;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  ed;
    logic [3:0]  es;
    logic        er;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic v, logic [15:0] data, logic [3:0] blank,
                              logic [3:0] ed, logic [3:0] es, logic er, logic ef);
    vec_t r;
    r.n = n; r.v = v; r.data = data; r.blank = blank;
    r.ed = ed; r.es = es; r.er = er; r.ef = ef;
    vecs.push_back(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [3:0] ed, logic [3:0] es, logic er, logic ef);
    checks++;
    if (d !== ed || ssd_ctl !== es || load_ready !== er || frame_done !== ef) begin
      errors++;
      $display("FAIL %s: got d=%h ssd_ctl=%b load_ready=%b frame_done=%b, want d=%h ssd_ctl=%b load_ready=%b frame_done=%b",
               name, d, ssd_ctl, load_ready, frame_done, ed, es, er, ef);
    end
  endtask

  initial begin
    // Edge counts in comments are rising edges since reset release.
    add(1,  1, 16'h4321, 4'b0000, 4'h0, 4'b1110, 0, 0); // k1 accept
    add(3,  0, 0, 0,              4'h0, 4'b1101, 0, 0); // k4
    add(12, 0, 0, 0,              4'h1, 4'b1110, 1, 1); // k16 commit
    add(1,  0, 0, 0,              4'h1, 4'b1110, 1, 0);
    add(3,  0, 0, 0,              4'h2, 4'b1101, 1, 0); // k20
    add(4,  0, 0, 0,              4'h3, 4'b1011, 1, 0);
    add(4,  0, 0, 0,              4'h4, 4'b0111, 1, 0); // k28
    add(3,  0, 0, 0,              4'h4, 4'b0111, 1, 0); // k31
    add(1,  0, 0, 0,              4'h1, 4'b1110, 1, 1); // k32 boundary
    add(1,  1, 16'hAAAA, 4'b0000, 4'h1, 4'b1110, 0, 0); // k33
    add(1,  1, 16'hBBBB, 4'b0000, 4'h1, 4'b1110, 0, 0); // k34 ignored
    add(14, 0, 0, 0,              4'hA, 4'b1110, 1, 1); // k48
    add(4,  0, 0, 0,              4'hA, 4'b1101, 1, 0);
    add(4,  0, 0, 0,              4'hA, 4'b1011, 1, 0);
    add(4,  0, 0, 0,              4'hA, 4'b0111, 1, 0);
    add(4,  0, 0, 0,              4'hA, 4'b1110, 1, 1); // k64 no commit
    add(15, 0, 0, 0,              4'hA, 4'b0111, 1, 0); // k79
    add(1,  1, 16'h0012, 4'b1100, 4'hA, 4'b1110, 0, 1); // k80 collision
    add(4,  0, 0, 0,              4'hA, 4'b1101, 0, 0); // k84
    add(12, 0, 0, 0,              4'h2, 4'b1110, 1, 1); // k96
    add(4,  0, 0, 0,              4'h1, 4'b1101, 1, 0);
    add(4,  0, 0, 0,              4'h0, 4'b1111, 1, 0); // blanked
    add(4,  0, 0, 0,              4'h0, 4'b1111, 1, 0);
    add(4,  0, 0, 0,              4'h2, 4'b1110, 1, 1); // k112
    add(4,  0, 0, 0,              4'h1, 4'b1101, 1, 0); // k116 SCAN1
    add(1,  1, 16'h9876, 4'b0000, 4'h1, 4'b1101, 0, 0); // k117 mid-frame load
    add(3,  0, 0, 0,              4'h0, 4'b1111, 0, 0); // old frame kept
    add(4,  0, 0, 0,              4'h0, 4'b1111, 0, 0);
    add(4,  0, 0, 0,              4'h6, 4'b1110, 1, 1); // k128
    add(4,  0, 0, 0,              4'h7, 4'b1101, 1, 0);
    add(4,  0, 0, 0,              4'h8, 4'b1011, 1, 0);
    add(4,  0, 0, 0,              4'h9, 4'b0111, 1, 0); // k140

    rst = 1'b1; load_valid = 1'b0; load_data = 16'h0; load_blank = 4'h0;
    step(); step();
    check("reset_state", 4'h0, 4'b1110, 1'b1, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      load_valid = vecs[i].v;
      load_data  = vecs[i].data;
      load_blank = vecs[i].blank;
      step();
      load_valid = 1'b0;
      for (int c = 1; c < vecs[i].n; c++) step();
      check($sformatf("vec%0d", i), vecs[i].ed, vecs[i].es, vecs[i].er, vecs[i].ef);
    end

    // Pending frame in flight, then reset asserted between clock edges.
    load_valid = 1'b1; load_data = 16'h5555; load_blank = 4'b0000;
    step();
    load_valid = 1'b0;
    check("pend_before_rst", 4'h9, 4'b0111, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst", 4'h0, 4'b1110, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    repeat (4) step();
    check("post_rst_scan1", 4'h0, 4'b1101, 1'b1, 1'b0);
    repeat (12) step();
    check("post_rst_no_commit", 4'h0, 4'b1110, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctl.md
SSD_SCAN_CTL -- requirements
Module: ssd_scan_ctl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 17: refresh counter width; each digit is held for 2^CNT_W clk cycles.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port load_valid  input  1  new frame offered on load_data/load_blank.
REQ-005 The block SHALL have port load_data  input  16  four BCD/hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 The block SHALL have port load_blank  input  4  per-digit blank mask; 1 means the digit stays dark.
REQ-007 The block SHALL have port load_ready  output  1  block can accept a frame.
REQ-008 The block SHALL have port d  output  4  value of the active digit, to the shared segment decoder.
REQ-009 The block SHALL have port ssd_ctl  output  4  active-low digit enables; bit n drives digit n.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse on each frame boundary.

Function
REQ-011 The block SHALL run a CNT_W-bit free-running counter; tick = counter at all-ones; the counter then wraps to 0.
REQ-012 The block SHALL hold a 2-bit digit index with states SCAN0->SCAN1->SCAN2->SCAN3->SCAN0, advancing only on the edge where tick is true.
REQ-013 The block SHALL register all outputs, so the new digit's d and ssd_ctl appear in the cycle after the tick edge.
REQ-014 In state SCANn, the block SHALL drive d = display buffer digit n, and ssd_ctl = all ones except bit n = 0.
REQ-015 If the display blank bit for digit n is 1, the block SHALL drive ssd_ctl = 4'b1111 in state SCANn; d still carries the digit value.
REQ-016 The block SHALL treat a tick in SCAN3 as the frame boundary.
REQ-017 The block SHALL double-buffer frames: display buffer (16+4 bits) and pending buffer (16+4 bits) plus a pending flag.
REQ-018 load_ready SHALL equal NOT pending.
REQ-019 Handshake: on an edge with load_valid=1 and load_ready=1, the block SHALL capture load_data/load_blank into the pending buffer and set pending.
REQ-020 Pending full: while load_ready=0, the block SHALL ignore load_valid and leave the pending buffer unchanged.
REQ-021 At the frame boundary with pending=1, the block SHALL copy the pending buffer to the display buffer and clear pending; load_ready returns to 1 in the next cycle.
REQ-022 Simultaneous accept and frame boundary (pending=0): the block SHALL place the data in the pending buffer only; it displays from the next boundary. No partial-frame update.
REQ-023 The block SHALL update the display buffer only at a frame boundary, so no frame mixes old and new digits.
REQ-024 The block SHALL assert frame_done for exactly one cycle following each frame boundary edge, whether or not a commit occurred.

Reset
REQ-025 While rst=1, the block SHALL immediately force: counter=0, state SCAN0, display data=0, display blank=4'b0000, pending=0.
REQ-026 While rst=1, the block SHALL force outputs d=4'h0, ssd_ctl=4'b1110, load_ready=1, frame_done=0.
REQ-027 Reset asserted mid-frame or with pending=1 SHALL discard the pending frame; the first tick after release moves to SCAN1.

Verification (CNT_W=2, tick every 4 cycles)
REQ-028 Reset check: assert rst mid-scan -> outputs change asynchronously, without waiting for clk, to d=0, ssd_ctl=1110, load_ready=1.
REQ-029 Scan check: load 16'h4321 with blank=0 after reset -> after the first boundary, the sequence is (d,ssd_ctl) = (1,1110),(2,1101),(3,1011),(4,0111), each held for 4 cycles, repeating; frame_done pulses every 16 cycles.
REQ-030 Backpressure check: load 16'hAAAA then 16'hBBBB back-to-back -> 16'hAAAA is accepted and load_ready=0; 16'hBBBB is ignored until after the boundary; the display shows A digits only.
REQ-031 Boundary collision check: present load_valid exactly on the SCAN3 tick edge -> the data appears only after the following boundary, 16 cycles later.
REQ-032 Blank check: load 16'h0012 with blank=4'b1100 -> ssd_ctl=1111 during SCAN2 and SCAN3; digits 0 and 1 light normally.
REQ-033 Tear check: accept a new frame while in SCAN1 -> SCAN1..SCAN3 still show old digits; the new digits start at SCAN0.
